uart_host_sequencer: RTL and testbench

Host-side command initiator for the TPU UART command protocol. It serialises command descriptors into opcode and payload byte streams for a byte-level UART transmitter, then collects response bytes from a byte-level UART receiver, with a timeout. It sits at the host end of the UART link, either in an FPGA self-test harness or in a companion controller. It drives the TPU's UART controller exactly as an external PC would.

---
 rtl/uart_host_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_uart_host_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_host_sequencer.sv
// uart_host_sequencer
//   Host-side command initiator for the TPU UART command protocol. A command
//   descriptor (opcode + 32-bit payload) is serialised into an opcode byte and
//   optional payload bytes (LSB first) for a byte-level UART transmitter. For
//   read opcodes the response bytes from a byte-level UART receiver are then
//   collected, with an inter-byte timeout.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake; accepted only in IDLE
//   cmd_op, cmd_payload : opcode (1..5 legal) and payload (ops 1 and 2)
//   tx_data/tx_valid/tx_ready : byte stream towards the UART transmitter
//   rx_data/rx_valid    : byte strobe from the UART receiver
//   rsp_valid           : one-cycle completion pulse (DONE state)
//   rsp_data            : captured response bytes, byte i at [8i+7:8i]
//   rsp_timeout         : qualifies rsp_valid, response timed out
//   rsp_error           : qualifies rsp_valid, illegal opcode
//   busy, dbg_state     : status / current state encoding
module uart_host_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_payload,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rsp_valid,
  output logic [63:0] rsp_data,
  output logic        rsp_timeout,
  output logic        rsp_error,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  // The WAIT_RSP cycle in which the counter would reach TIMEOUT_CYCLES is the
  // last one; completion follows on the next edge.
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_SEND_OP      = 3'd1,
    S_SEND_PAYLOAD = 3'd2,
    S_WAIT_RSP     = 3'd3,
    S_DONE         = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [31:0]   payload_q, payload_d;
  logic [3:0]    cnt_q, cnt_d;        // payload byte index / response byte count
  logic [TW-1:0] tmr_q, tmr_d;
  logic [63:0]   rsp_data_q, rsp_data_d;
  logic          timeout_q, timeout_d;
  logic          error_q, error_d;

  logic          cmd_legal;
  logic [3:0]    rsp_len;
  logic [7:0]    payload_byte;

  assign cmd_legal = (cmd_op != 3'd0) && (cmd_op != 3'd6) && (cmd_op != 3'd7);
  assign rsp_len   = (op_q == 3'd4) ? 4'd1 : 4'd8;

  always_comb begin
    payload_byte = 8'h00;
    case (cnt_q[1:0])
      2'd0:    payload_byte = payload_q[7:0];
      2'd1:    payload_byte = payload_q[15:8];
      2'd2:    payload_byte = payload_q[23:16];
      default: payload_byte = payload_q[31:24];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= 3'd0;
      payload_q  <= 32'd0;
      cnt_q      <= 4'd0;
      tmr_q      <= '0;
      rsp_data_q <= 64'd0;
      timeout_q  <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      payload_q  <= payload_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      rsp_data_q <= rsp_data_d;
      timeout_q  <= timeout_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    payload_d  = payload_q;
    cnt_d      = cnt_q;
    tmr_d      = tmr_q;
    rsp_data_d = rsp_data_q;
    timeout_d  = timeout_q;
    error_d    = error_q;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d       = cmd_op;
          payload_d  = cmd_payload;
          rsp_data_d = 64'd0;
          timeout_d  = 1'b0;
          error_d    = !cmd_legal;
          cnt_d      = 4'd0;
          tmr_d      = '0;
          // Illegal opcodes send nothing and report straight away.
          state_d    = cmd_legal ? S_SEND_OP : S_DONE;
        end
      end

      S_SEND_OP: begin
        tx_valid = 1'b1;
        tx_data  = {5'b00000, op_q};
        if (tx_ready) begin
          cnt_d = 4'd0;
          tmr_d = '0;
          case (op_q)
            3'd1, 3'd2: state_d = S_SEND_PAYLOAD;
            3'd4, 3'd5: state_d = S_WAIT_RSP;
            default:    state_d = S_DONE;
          endcase
        end
      end

      S_SEND_PAYLOAD: begin
        tx_valid = 1'b1;
        tx_data  = payload_byte;
        if (tx_ready) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd3) begin
            state_d = S_DONE;
          end
        end
      end

      S_WAIT_RSP: begin
        // A byte arriving on the expiry cycle takes priority over the timeout.
        if (rx_valid) begin
          rsp_data_d[{cnt_q[2:0], 3'b000} +: 8] = rx_data;
          cnt_d = cnt_q + 4'd1;
          tmr_d = '0;
          if ((cnt_q + 4'd1) == rsp_len) begin
            state_d = S_DONE;
          end
        end else if (tmr_q == TMR_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign dbg_state   = state_q;
  assign rsp_valid   = (state_q == S_DONE);
  assign rsp_timeout = rsp_valid && timeout_q;
  assign rsp_error   = rsp_valid && error_q;
  assign rsp_data    = rsp_data_q;

endmodule

// File: tb/tb_uart_host_sequencer.sv
// Directed testbench for uart_host_sequencer (TIMEOUT_CYCLES = 16).
// Inputs are driven and outputs sampled on the falling edge; "cycle k" is the
// k-th falling edge after the accepting rising edge.
module tb_uart_host_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_payload;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        rsp_timeout;
  logic        rsp_error;
  logic        busy;
  logic [2:0]  dbg_state;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_host_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_payload(cmd_payload),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .rsp_error(rsp_error),
    .busy(busy), .dbg_state(dbg_state)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] payload;
    int          nbytes;     // bytes expected on tx (opcode + payload)
    logic [39:0] bytes;      // byte 0 in [7:0]
    int          done_cyc;   // cycle in which rsp_valid is expected
    logic        err;
    logic        tmo;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Issue a command, then scramble the cmd_* inputs so the latched copy is
  // what gets used. Returns at the falling edge of cycle 1.
  task automatic issue(input logic [2:0] op, input logic [31:0] pl);
    @(negedge clk);
    chk("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_payload = pl;
    @(negedge clk);
    cmd_valid   = 1'b0;
    cmd_op      = 3'd5;
    cmd_payload = 32'hFFFF_FFFF;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          cyc;
    int          nb;
    logic [39:0] got;
    bit          seen;
    tx_ready = 1'b1;
    issue(v.op, v.payload);
    cyc = 1; nb = 0; got = '0; seen = 0;
    while (cyc <= 40 && !seen) begin
      if (rsp_valid) begin
        seen = 1;
        chk("done_cycle", 64'(cyc), 64'(v.done_cyc));
        chk("rsp_error", {63'd0, rsp_error}, {63'd0, v.err});
        chk("rsp_timeout", {63'd0, rsp_timeout}, {63'd0, v.tmo});
        chk("rsp_data", rsp_data, 64'd0);
        chk("dbg_state_done", {61'd0, dbg_state}, 64'd4);
      end else begin
        if (tx_valid) begin
          if (nb < 5) got[nb*8 +: 8] = tx_data;
          nb++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!seen) chk("rsp_valid_seen", 64'd0, 64'd1);
    chk("tx_count", 64'(nb), 64'(v.nbytes));
    chk("tx_bytes", {24'd0, got}, {24'd0, v.bytes});
    @(negedge clk);
    chk("back_idle", {61'd0, rsp_valid, cmd_ready, rsp_error}, {61'd0, 3'b010});
    $display("[TB] vec %0d op=%0d bytes=%0d done_cycle=%0d", idx, v.op, nb, cyc);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] got;
    logic [7:0]  held;
    bit          held_v;
    bit          seen;
    int          nb;
    logic [3:0]  pat;

    vecs[0] = '{3'd1, 32'h0403_0201, 5, 40'h04_03_02_01_01, 6, 1'b0, 1'b0};
    vecs[1] = '{3'd2, 32'hCAFE_F00D, 5, 40'hCA_FE_F0_0D_02, 6, 1'b0, 1'b0};
    vecs[2] = '{3'd3, 32'h1234_5678, 1, 40'h03, 2, 1'b0, 1'b0};
    vecs[3] = '{3'd6, 32'h1111_1111, 0, 40'h0, 1, 1'b1, 1'b0};
    vecs[4] = '{3'd0, 32'h2222_2222, 0, 40'h0, 1, 1'b1, 1'b0};
    vecs[5] = '{3'd7, 32'h3333_3333, 0, 40'h0, 1, 1'b1, 1'b0};
    vecs[6] = '{3'd4, 32'h0, 1, 40'h04, 18, 1'b0, 1'b1};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_payload = 32'd0;
    tx_ready = 1'b1; rx_valid = 1'b0; rx_data = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {tx_data, rsp_data[7:0], dbg_state, cmd_ready, tx_valid, rsp_valid, rsp_timeout, rsp_error, busy},
        {8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("reset_rsp_data", rsp_data, 64'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // TX backpressure, tx_ready pattern 1-0-0-1 repeating.
    pat = 4'b1001;
    issue(3'd2, 32'hBEEF_1234);
    got = '0; nb = 0; held_v = 0; seen = 0; held = 8'h00;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      tx_ready = pat[3 - ((cyc - 1) % 4)];
      if (rsp_valid) begin
        seen = 1;
      end else begin
        if (held_v) chk("bp_hold", {55'd0, tx_valid, tx_data}, {55'd0, 1'b1, held});
        if (tx_valid) begin
          if (tx_ready) begin
            if (nb < 5) got[nb*8 +: 8] = tx_data;
            nb++;
            held_v = 0;
          end else begin
            held   = tx_data;
            held_v = 1;
          end
        end
        @(negedge clk);
      end
    end
    chk("bp_seen", {63'd0, seen}, 64'd1);
    chk("bp_count", 64'(nb), 64'd5);
    chk("bp_bytes", {24'd0, got}, {24'd0, 40'hBE_EF_12_34_02});
    $display("[TB] backpressure op=2 bytes=%0d", nb);
    tx_ready = 1'b1;

    // READ_RESULT with 3-cycle gaps between response bytes.
    issue(3'd5, 32'h0);
    @(negedge clk);                        // cycle 2, WAIT_RSP
    chk("rd_wait_state", {61'd0, dbg_state}, 64'd3);
    for (int i = 0; i < 8; i++) begin
      repeat (3) @(negedge clk);
      chk("rd_no_early_valid", {63'd0, rsp_valid}, 64'd0);
      rx_valid = 1'b1;
      rx_data  = 8'(8'h11 * (i + 1));
      @(negedge clk);
      rx_valid = 1'b0;
      if (i < 7) chk("rd_not_done", {63'd0, rsp_valid}, 64'd0);
    end
    chk("rd_valid", {63'd0, rsp_valid}, 64'd1);
    chk("rd_data", rsp_data, 64'h8877_6655_4433_2211);
    chk("rd_flags", {62'd0, rsp_timeout, rsp_error}, 64'd0);
    @(negedge clk);
    chk("rd_hold", rsp_data, 64'h8877_6655_4433_2211);
    $display("[TB] read_result data=0x%0h", rsp_data);

    // Stray rx byte while IDLE is dropped.
    rx_valid = 1'b1; rx_data = 8'hFF;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    chk("stray_rx", rsp_data, 64'h8877_6655_4433_2211);
    $display("[TB] stray rx in idle");

    // READ_STATUS with the byte arriving on the expiry cycle.
    issue(3'd4, 32'h0);
    repeat (16) @(negedge clk);            // cycle 17, last WAIT_RSP cycle
    chk("coin_pre", {60'd0, rsp_valid, dbg_state}, {60'd0, 1'b0, 3'd3});
    rx_valid = 1'b1; rx_data = 8'hA5;
    @(negedge clk);                        // cycle 18
    rx_valid = 1'b0;
    chk("coin_valid", {63'd0, rsp_valid}, 64'd1);
    chk("coin_timeout", {63'd0, rsp_timeout}, 64'd0);
    chk("coin_data", rsp_data, 64'hA5);
    $display("[TB] read_status byte on expiry cycle");

    // READ_RESULT with one byte then timeout; counter restarts at the byte.
    issue(3'd5, 32'h0);
    @(negedge clk);                        // cycle 2
    rx_valid = 1'b1; rx_data = 8'h5A;
    @(negedge clk);                        // cycle 3
    rx_valid = 1'b0;
    repeat (15) @(negedge clk);            // cycle 18
    chk("part_pre", {63'd0, rsp_valid}, 64'd0);
    @(negedge clk);                        // cycle 19
    chk("part_valid", {62'd0, rsp_valid, rsp_timeout}, 64'd3);
    chk("part_data", rsp_data, 64'h5A);
    $display("[TB] read_result partial timeout");

    // Reset during payload byte 2 with tx_ready low.
    issue(3'd1, 32'hDDCC_BBAA);
    repeat (3) @(negedge clk);             // cycle 4, payload byte 2 shown
    chk("rst_pre", {55'd0, tx_valid, tx_data}, {55'd0, 1'b1, 8'hCC});
    tx_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rst_state",
        {59'd0, tx_valid, rsp_valid, cmd_ready, busy, dbg_state == 3'd0},
        {59'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
    rst = 1'b0; tx_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid || tx_valid) seen = 1;
    end
    chk("rst_quiet", {63'd0, seen}, 64'd0);
    $display("[TB] reset mid-command");
    run_vec(7, vecs[2]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
